// File: rtl/pipe_pkg.sv
// Shared pipeline-stage constants: occupancy encoding reused by the
// hazard unit (EMPTY/BUSY/FULL == entries held).
package pipe_pkg;

    localparam int OCC_W = 2;

    typedef logic [OCC_W-1:0] occ_t;

    localparam occ_t ST_EMPTY = 2'd0;
    localparam occ_t ST_BUSY  = 2'd1;
    localparam occ_t ST_FULL  = 2'd2;

endpackage

// File: rtl/pipe_data_reg.sv
// Payload register with load enable and synchronous clear.
// Ports: clk_i, rst_i/clr_i (load RESET_VALUE), ld_i, d_i, q_o.
module pipe_data_reg #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             ld_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            data_q <= RESET_VALUE;
        end else if (ld_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/pipe_stage_skid_param.sv
// Elastic pipeline stage: valid/ready in and out, one-entry skid buffer,
// registered in_ready, synchronous flush and occupancy reporting.
// Ports: clk, rst, flush; in_valid/in_ready/in_data upstream;
//        out_valid/out_ready/out_data downstream; occupancy (0..2).
module pipe_stage_skid_param
    import pipe_pkg::*;
#(
    parameter int               WIDTH          = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE    = '0,
    parameter bit               CLEAR_ON_FLUSH = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [OCC_W-1:0] occupancy
);

    occ_t             state_q;
    occ_t             state_d;
    logic             main_ld;
    logic             main_sel_skid;
    logic             skid_ld;
    logic             clr;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        main_ld       = 1'b0;
        main_sel_skid = 1'b0;
        skid_ld       = 1'b0;
        unique case (state_q)
            ST_EMPTY: begin
                if (in_valid) begin
                    main_ld = 1'b1;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (in_valid && out_ready) begin
                    main_ld = 1'b1;
                end else if (in_valid) begin
                    skid_ld = 1'b1;
                    state_d = ST_FULL;
                end else if (out_ready) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so only the skid drains forward
                if (out_ready) begin
                    main_ld       = 1'b1;
                    main_sel_skid = 1'b1;
                    state_d       = ST_BUSY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // flush drops everything held plus any beat accepted this cycle
        if (flush) begin
            state_d = ST_EMPTY;
            main_ld = 1'b0;
            skid_ld = 1'b0;
        end
    end

    always_comb begin
        out_valid = (state_q != ST_EMPTY);
        in_ready  = (state_q != ST_FULL) && !rst;
        occupancy = state_q;
    end

    assign main_d = main_sel_skid ? skid_q : in_data;
    assign clr    = flush && CLEAR_ON_FLUSH;

    pipe_data_reg #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RESET_VALUE)
    ) u_main (
        .clk_i (clk),
        .rst_i (rst),
        .clr_i (clr),
        .ld_i  (main_ld),
        .d_i   (main_d),
        .q_o   (main_q)
    );

    pipe_data_reg #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RESET_VALUE)
    ) u_skid (
        .clk_i (clk),
        .rst_i (rst),
        .clr_i (clr),
        .ld_i  (skid_ld),
        .d_i   (in_data),
        .q_o   (skid_q)
    );

    assign out_data = main_q;

endmodule

// File: tb/tb_pipe_stage_skid_param.sv
// Bench for pipe_stage_skid_param: four instances in lockstep
// (32b clear/hold on flush, 8b, 64b) against a queue model.
module tb_pipe_stage_skid_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [63:0] in_data;

    logic        ir_a, ov_a, ir_b, ov_b, ir_c, ov_c, ir_d, ov_d;
    logic [31:0] od_a, od_b;
    logic [7:0]  od_c;
    logic [63:0] od_d;
    logic [1:0]  oc_a, oc_b, oc_c, oc_d;

    int errors = 0;
    int checks = 0;
    int beats  = 0;
    int cyc    = 0;

    logic [63:0] mq[$];

    always #5 clk = ~clk;

    pipe_stage_skid_param #(.WIDTH(32), .CLEAR_ON_FLUSH(1'b1)) dut_a (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ir_a), .in_data(in_data[31:0]),
        .out_valid(ov_a), .out_ready(out_ready), .out_data(od_a),
        .occupancy(oc_a)
    );

    pipe_stage_skid_param #(.WIDTH(32), .CLEAR_ON_FLUSH(1'b0)) dut_b (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ir_b), .in_data(in_data[31:0]),
        .out_valid(ov_b), .out_ready(out_ready), .out_data(od_b),
        .occupancy(oc_b)
    );

    pipe_stage_skid_param #(.WIDTH(8), .CLEAR_ON_FLUSH(1'b1)) dut_c (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ir_c), .in_data(in_data[7:0]),
        .out_valid(ov_c), .out_ready(out_ready), .out_data(od_c),
        .occupancy(oc_c)
    );

    pipe_stage_skid_param #(.WIDTH(64), .CLEAR_ON_FLUSH(1'b0)) dut_d (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ir_d), .in_data(in_data),
        .out_valid(ov_d), .out_ready(out_ready), .out_data(od_d),
        .occupancy(oc_d)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; model holds at most two beats, FIFO order.
    task automatic tick();
        bit          acc;
        bit          pop;
        logic [63:0] din;
        acc = in_valid && (mq.size() < 2) && !rst;
        pop = (mq.size() > 0) && out_ready;
        din = in_data;
        @(posedge clk);
        #1;
        cyc++;
        if (rst || flush) begin
            mq.delete();
        end else begin
            if (pop) begin
                void'(mq.pop_front());
                beats++;
            end
            if (acc) mq.push_back(din);
        end
    endtask

    task automatic chk_model();
        logic [63:0] n;
        logic [63:0] h;
        n = 64'(mq.size());
        chk("occ_a", 64'(oc_a), n);
        chk("occ_c", 64'(oc_c), n);
        chk("occ_d", 64'(oc_d), n);
        chk("ov_a", 64'(ov_a), 64'(n != 0));
        chk("ov_d", 64'(ov_d), 64'(n != 0));
        chk("ir_c", 64'(ir_c), 64'(n < 2));
        chk("ir_d", 64'(ir_d), 64'(n < 2));
        if (mq.size() > 0) begin
            h = mq[0];
            chk("od_a", 64'(od_a), 64'(h[31:0]));
            chk("od_b", 64'(od_b), 64'(h[31:0]));
            chk("od_c", 64'(od_c), 64'(h[7:0]));
            chk("od_d", od_d, h);
        end
    endtask

    task automatic fill_ab(input logic [63:0] a, input logic [63:0] b);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = a;
        tick();
        in_data = b;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        logic ra, rb, rc, rd;

        // reset held two cycles with a pending beat
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'hDEAD;
        out_ready = 1'b0;
        #1;
        chk("rst_ir_a0", 64'(ir_a), 64'd0);
        tick();
        chk("rst_ir_a1", 64'(ir_a), 64'd0);
        chk("rst_ir_d1", 64'(ir_d), 64'd0);
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("post_ov_a", 64'(ov_a), 64'd0);
        chk("post_od_a", 64'(od_a), 64'd0);
        chk("post_od_d", od_d, 64'd0);
        chk("post_occ_a", 64'(oc_a), 64'd0);
        chk("post_ir_a", 64'(ir_a), 64'd1);
        chk("post_ir_b", 64'(ir_b), 64'd1);

        // streaming at full throughput
        out_ready = 1'b1;
        for (int v = 1; v <= 4; v++) begin
            in_valid = 1'b1;
            in_data  = 64'(v);
            tick();
            chk("str_od", 64'(od_a), 64'(v));
            chk("str_ov", 64'(ov_a), 64'd1);
            chk("str_occ", 64'(oc_a), 64'd1);
        end
        in_valid = 1'b0;
        tick();
        chk("str_drain", 64'(oc_a), 64'd0);

        // backpressure into the skid
        fill_ab(64'hA, 64'hB);
        chk("bp_occ", 64'(oc_a), 64'd2);
        chk("bp_ir", 64'(ir_a), 64'd0);
        chk("bp_od", 64'(od_a), 64'hA);
        tick();
        chk("bp_hold_od", 64'(od_a), 64'hA);
        chk("bp_hold_occ", 64'(oc_a), 64'd2);
        out_ready = 1'b1;
        #1;
        chk("bp_ir_stable", 64'(ir_a), 64'd0);
        chk("bp_out0", 64'(od_a), 64'hA);
        tick();
        chk("bp_out1", 64'(od_a), 64'hB);
        chk("bp_occ1", 64'(oc_a), 64'd1);
        tick();
        chk("bp_occ0", 64'(oc_a), 64'd0);

        // flush while full with a beat offered
        fill_ab(64'hA, 64'hB);
        chk("fl_pre", 64'(oc_a), 64'd2);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 64'hC;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_ov_a", 64'(ov_a), 64'd0);
        chk("fl_od_a", 64'(od_a), 64'd0);
        chk("fl_occ_a", 64'(oc_a), 64'd0);
        chk("fl_ir_a", 64'(ir_a), 64'd1);
        chk("fl_ov_b", 64'(ov_b), 64'd0);
        chk("fl_od_b", 64'(od_b), 64'hA);
        out_ready = 1'b1;
        tick();
        tick();
        chk("fl_no_c_a", 64'(ov_a), 64'd0);
        chk("fl_no_c_b", 64'(ov_b), 64'd0);

        // reset while full
        fill_ab(64'h11, 64'h22);
        rst = 1'b1;
        #1;
        chk("rstf_ir", 64'(ir_a), 64'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("rstf_occ", 64'(oc_b), 64'd0);
        chk("rstf_od_b", 64'(od_b), 64'd0);
        chk("rstf_ir", 64'(ir_b), 64'd1);

        // randomised traffic against the queue model
        beats = 0;
        cyc   = 0;
        while (beats < 10000 && cyc < 60000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = {$urandom, $urandom};
            flush     = ($urandom_range(0, 255) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            ra = ir_a; rb = ir_b; rc = ir_c; rd = ir_d;
            out_ready = ~out_ready;
            #1;
            chk("ir_indep_a", 64'(ir_a), 64'(ra));
            chk("ir_indep_b", 64'(ir_b), 64'(rb));
            chk("ir_indep_c", 64'(ir_c), 64'(rc));
            chk("ir_indep_d", 64'(ir_d), 64'(rd));
            out_ready = ~out_ready;
            tick();
            chk_model();
        end
        chk("rand_beats", 64'(beats >= 10000), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
